// File: rtl/mem_ctrl.sv
// mem_ctrl: single/burst read-write sequencer in front of a 1024x8 single-port RAM.
// Every RAM access is a one-cycle registered strobe followed by a deselect cycle.
module mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    WR_ACC  = 3'd2,
    WR_GAP  = 3'd3,
    RD_ACC  = 3'd4,
    RD_RSP  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] beat_cnt;
  logic       last_beat;

  // Address wraps naturally at 2**ADDR_W, so bursts may cross the top of memory.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign last_beat = (beat_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_wr ? WR_WAIT : RD_ACC;
      end
      WR_WAIT: begin
        wdata_ready = 1'b1;
        if (wdata_valid) state_nxt = WR_ACC;
      end
      WR_ACC:  state_nxt = WR_GAP;
      WR_GAP:  state_nxt = last_beat ? IDLE : WR_WAIT;
      RD_ACC:  state_nxt = RD_RSP;
      RD_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = last_beat ? IDLE : RD_ACC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from next-state so they are glitch-free and align
  // with the cycle spent in an access state; address/data only move outside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rsp_data <= '0;
      done     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      mem_cs <= (state_nxt == WR_ACC) || (state_nxt == RD_ACC);
      mem_wr <= (state_nxt == WR_ACC);
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr;
            beat_cnt <= req_len;
          end
        end
        WR_WAIT: begin
          if (wdata_valid) mem_din <= wdata;
        end
        WR_GAP: begin
          if (last_beat) begin
            done <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt - 4'd1;
            mem_addr <= addr_next(mem_addr);
          end
        end
        RD_ACC: rsp_data <= mem_dout;
        RD_RSP: begin
          if (rsp_ready) begin
            if (last_beat) begin
              done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 4'd1;
              mem_addr <= addr_next(mem_addr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural RAM plus scoreboards for write strobes and read responses.
module tb_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_wr;
  logic [9:0] req_addr;
  logic [3:0] req_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       done;
  logic       mem_cs, mem_wr;
  logic [9:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  mem_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram     [1024];
  logic [7:0]  ref_mem [1024];
  logic [7:0]  wbuf    [16];
  logic [17:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int wr_strobes = 0;
  int rd_beats   = 0;
  int done_cnt   = 0;
  bit mon_en     = 1'b0;

  assign mem_dout = mem_cs ? ram[mem_addr] : 8'hEE;
  always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_din;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_wr) begin
        n_checks++;
        if (mem_cs !== 1'b1) $display("FAIL wr_without_cs: mem_cs=%b required 1", mem_cs);
        else n_pass++;
      end
      if (mem_cs && mem_wr) begin
        logic [17:0] e;
        wr_strobes++;
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          $display("FAIL wr_unexpected: addr=%0d data=%02h required no write", mem_addr, mem_din);
        end else begin
          e = exp_wr_q.pop_front();
          if ({mem_addr, mem_din} !== e)
            $display("FAIL wr_strobe: addr=%0d data=%02h required addr=%0d data=%02h",
                     mem_addr, mem_din, e[17:8], e[7:0]);
          else n_pass++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        logic [7:0] r;
        rd_beats++;
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          $display("FAIL rd_unexpected: rsp_data=%02h required no response", rsp_data);
        end else begin
          r = exp_rd_q.pop_front();
          if (rsp_data !== r) $display("FAIL rd_data: rsp_data=%02h required %02h", rsp_data, r);
          else n_pass++;
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drive a command from posedge+1; returns at posedge+1 after the accept edge.
  task automatic start_req(input bit wr, input logic [9:0] a, input logic [3:0] l, input bit keep);
    bit ok = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!keep) req_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL req_accept: req_ready never seen required 1");
    else n_pass++;
  endtask

  task automatic push_wdata(input logic [7:0] d);
    bit ok = 1'b0;
    wdata_valid = 1'b1; wdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (wdata_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL wdata_accept: wdata_ready never seen required 1");
    else n_pass++;
  endtask

  // Returns on the falling edge of the cycle in which done is high.
  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
  endtask

  task automatic write_burst(input logic [9:0] a, input logic [3:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      logic [9:0] ak;
      ak = a + 10'(k);
      exp_wr_q.push_back({ak, wbuf[k]});
      ref_mem[ak] = wbuf[k];
    end
    start_req(1'b1, a, l, 1'b0);
    for (int k = 0; k <= int'(l); k++) push_wdata(wbuf[k]);
  endtask

  task automatic start_read(input logic [9:0] a, input logic [3:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      logic [9:0] ak;
      ak = a + 10'(k);
      exp_rd_q.push_back(ref_mem[ak]);
    end
    rsp_ready = 1'b1;
    start_req(1'b0, a, l, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_cs, mem_wr, mem_addr, mem_din, rsp_data, rsp_valid, done, wdata_ready} !== 30'd0)
      $display("FAIL reset_outputs: cs=%b wr=%b addr=%0d din=%02h rdata=%02h rv=%b done=%b wr_rdy=%b required all 0",
               mem_cs, mem_wr, mem_addr, mem_din, rsp_data, rsp_valid, done, wdata_ready);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: req_ready=%b required 1", req_ready);
    else n_pass++;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int s0, d0, r0;
    bit found;
    for (int k = 0; k < 16; k++) wbuf[k] = 8'(2 * k);
    s0 = wr_strobes; d0 = done_cnt;
    write_burst(10'd0, 4'd15);
    wait_done(found);
    n_checks++;
    if (!found || req_ready !== 1'b1) $display("FAIL fill_wr_done: found=%b req_ready=%b required 1/1", found, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wr_strobes - s0 != 16 || done_cnt - d0 != 1)
      $display("FAIL fill_wr_counts: strobes=%0d dones=%0d required 16/1", wr_strobes - s0, done_cnt - d0);
    else n_pass++;
    r0 = rd_beats; d0 = done_cnt;
    start_read(10'd0, 4'd15);
    @(negedge clk);
    n_checks++;
    if (mem_cs !== 1'b1 || mem_wr !== 1'b0 || rsp_valid !== 1'b0 || mem_addr !== 10'd0)
      $display("FAIL rd_latency_acc: cs=%b wr=%b rv=%b addr=%0d required 1/0/0/0", mem_cs, mem_wr, rsp_valid, mem_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || mem_cs !== 1'b0)
      $display("FAIL rd_latency_rsp: rv=%b cs=%b required 1/0", rsp_valid, mem_cs);
    else n_pass++;
    wait_done(found);
    @(posedge clk); #1 rsp_ready = 1'b0;
    n_checks++;
    if (!found || rd_beats - r0 != 16 || done_cnt - d0 != 1)
      $display("FAIL fill_rd_counts: found=%b beats=%0d dones=%0d required 1/16/1", found, rd_beats - r0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_wrap;
    bit found;
    int r0;
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wbuf[3] = 8'hDD;
    write_burst(10'd1022, 4'd3);
    wait_done(found);
    @(posedge clk); #1;
    n_checks++;
    if (!found) $display("FAIL wrap_wr_done: done not seen required pulse");
    else n_pass++;
    r0 = rd_beats;
    start_read(10'd1022, 4'd3);
    wait_done(found);
    @(posedge clk); #1 rsp_ready = 1'b0;
    n_checks++;
    if (!found || rd_beats - r0 != 4) $display("FAIL wrap_rd: found=%b beats=%0d required 1/4", found, rd_beats - r0);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    bit found, bad;
    int r0;
    logic [7:0] held;
    r0 = rd_beats; bad = 1'b0;
    start_read(10'd0, 4'd2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) found = 1'b1;
    end
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    held = rsp_data;
    n_checks++;
    if (rsp_valid !== 1'b1 || held !== ref_mem[1])
      $display("FAIL bp_beat2: rv=%b data=%02h required 1/%02h", rsp_valid, held, ref_mem[1]);
    else n_pass++;
    repeat (4) begin
      @(negedge clk);
      if (rsp_data !== held || mem_cs !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL bp_stall_hold: data=%02h cs=%b rv=%b required %02h/0/1", rsp_data, mem_cs, rsp_valid, held);
    else n_pass++;
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done(found);
    @(posedge clk); #1 rsp_ready = 1'b0;
    n_checks++;
    if (!found || rd_beats - r0 != 3) $display("FAIL bp_beats: found=%b beats=%0d required 1/3", found, rd_beats - r0);
    else n_pass++;
  endtask

  task automatic test_write_stall;
    bit found, bad;
    int s0;
    bad = 1'b0; s0 = wr_strobes;
    exp_wr_q.push_back({10'd500, 8'h11}); ref_mem[500] = 8'h11;
    exp_wr_q.push_back({10'd501, 8'h22}); ref_mem[501] = 8'h22;
    start_req(1'b1, 10'd500, 4'd1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (mem_cs !== 1'b0 || wdata_ready !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL wstall_wait: cs=%b wdata_ready=%b required 0/1", mem_cs, wdata_ready);
    else n_pass++;
    @(posedge clk); #1;
    push_wdata(8'h11);
    push_wdata(8'h22);
    wait_done(found);
    @(posedge clk); #1;
    n_checks++;
    if (!found || wr_strobes - s0 != 2) $display("FAIL wstall_strobes: found=%b strobes=%0d required 1/2", found, wr_strobes - s0);
    else n_pass++;
    start_read(10'd499, 4'd3);
    wait_done(found);
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_busy;
    bit found, bad;
    bad = 1'b0;
    exp_wr_q.push_back({10'd100, 8'h33}); ref_mem[100] = 8'h33;
    exp_wr_q.push_back({10'd101, 8'h44}); ref_mem[101] = 8'h44;
    start_req(1'b1, 10'd100, 4'd1, 1'b1);
    req_wr = 1'b0; req_addr = 10'd200; req_len = 4'd0;
    exp_rd_q.push_back(ref_mem[200]);
    rsp_ready = 1'b1;
    push_wdata(8'h33);
    push_wdata(8'h44);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else if (req_ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || !found || req_ready !== 1'b1)
      $display("FAIL busy_ready: early_ready=%b found=%b ready_at_done=%b required 0/1/1", bad, found, req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_cs !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 10'd200)
      $display("FAIL busy_accept: cs=%b wr=%b addr=%0d required 1/0/200", mem_cs, mem_wr, mem_addr);
    else n_pass++;
    wait_done(found);
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    int d0, s0;
    bit found;
    for (int k = 0; k < 8; k++) wbuf[k] = 8'(8'h80 + k);
    for (int k = 0; k < 3; k++) begin
      exp_wr_q.push_back({10'(300 + k), wbuf[k]});
      ref_mem[300 + k] = wbuf[k];
    end
    d0 = done_cnt; s0 = wr_strobes;
    start_req(1'b1, 10'd300, 4'd7, 1'b0);
    for (int k = 0; k < 3; k++) push_wdata(wbuf[k]);
    rst = 1'b1;
    wdata_valid = 1'b1; wdata = 8'hF0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_cs !== 1'b0 || mem_wr !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rst_mid_state: cs=%b wr=%b done=%b ready=%b required 0/0/0/1", mem_cs, mem_wr, done, req_ready);
    else n_pass++;
    @(posedge clk); #1 wdata_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || wr_strobes - s0 != 3)
      $display("FAIL rst_mid_counts: dones=%0d strobes=%0d required 0/3", done_cnt - d0, wr_strobes - s0);
    else n_pass++;
    @(posedge clk); #1;
    start_read(10'd300, 4'd7);
    wait_done(found);
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    test_reset;
    test_fill;
    test_wrap;
    test_backpressure;
    test_write_stall;
    test_busy;
    test_reset_mid_burst;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0)
      $display("FAIL scoreboard_drain: wr_left=%0d rd_left=%0d required 0/0", exp_wr_q.size(), exp_rd_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
